// File: rtl/acq_ram_writer_pkg.sv
// Shared state encodings and default parameters for the acquisition SRAM writer.
// The control FSM owns capture/drain sequencing; the write FSM owns the SRAM strobe.
package acq_ram_writer_pkg;

    localparam int DEFAULT_BITS      = 16;
    localparam int DEFAULT_ADDR_BITS = 19;
    localparam int DEFAULT_FIFO_LOG2 = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_SETUP  = 2'd1,
        W_STROBE = 2'd2,
        W_HOLD   = 2'd3
    } write_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous flush; head word is always on dout.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
    import acq_ram_writer_pkg::*;
#(
    parameter int BITS      = DEFAULT_BITS,
    parameter int FIFO_LOG2 = DEFAULT_FIFO_LOG2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam int DEPTH = 2 ** FIFO_LOG2;

    logic [BITS-1:0]    mem [DEPTH];
    logic [FIFO_LOG2:0] wr_ptr;
    logic [FIFO_LOG2:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                     (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear && (!full || do_pop);
    assign dout    = mem[rd_ptr[FIFO_LOG2-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/acq_ram_writer.sv
// Captures disc-reader words through a small FIFO and writes them sequentially into
// an asynchronous SRAM using a setup/strobe/hold cycle (one word per 3 clocks sustained).
module acq_ram_writer
    import acq_ram_writer_pkg::*;
#(
    parameter int BITS      = DEFAULT_BITS,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int FIFO_LOG2 = DEFAULT_FIFO_LOG2
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [BITS-1:0]      DATA_IN,
    input  logic                 WRITE_IN,
    input  logic                 START,
    input  logic                 STOP,
    output logic [ADDR_BITS-1:0] SRAM_ADDR,
    output logic [BITS-1:0]      SRAM_DQ,
    output logic                 SRAM_WE_N,
    output logic                 BUSY,
    output logic                 RAM_FULL,
    output logic                 OVERRUN,
    output logic [ADDR_BITS:0]   WORD_COUNT,
    output ctrl_state_t          CTRL_STATE,
    output write_state_t         WRITE_STATE
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    ctrl_state_t  ctrl_state;
    write_state_t w_state;
    logic         abort_q;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_clear;
    logic            fifo_full;
    logic            fifo_empty;
    logic [BITS-1:0] fifo_dout;

    logic capturing;
    logic write_done;
    logic at_last;
    logic last_done;
    logic overrun_evt;

    assign CTRL_STATE  = ctrl_state;
    assign WRITE_STATE = w_state;

    // A START cycle belongs to the new capture: nothing is pushed, popped or counted in it.
    assign capturing   = (ctrl_state == CAPTURE) && !START && !RAM_FULL;
    assign write_done  = (w_state == W_HOLD) && !abort_q && !START;
    assign at_last     = (SRAM_ADDR == LAST_ADDR);
    assign last_done   = write_done && at_last;

    assign fifo_push   = capturing && WRITE_IN;
    assign fifo_pop    = !START && !fifo_empty &&
                         (((w_state == W_IDLE) && !RAM_FULL) || (write_done && !at_last));
    assign fifo_clear  = START || last_done;
    assign overrun_evt = fifo_push && fifo_full && !fifo_pop;

    sync_fifo #(
        .BITS      (BITS),
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (CLOCK),
        .rst   (RESET),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (DATA_IN),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Control FSM: capture window, drain after STOP or a full SRAM.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ctrl_state <= IDLE;
            BUSY       <= 1'b0;
            RAM_FULL   <= 1'b0;
            OVERRUN    <= 1'b0;
        end else if (START) begin
            ctrl_state <= CAPTURE;
            BUSY       <= 1'b1;
            RAM_FULL   <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            if (overrun_evt) OVERRUN  <= 1'b1;
            if (last_done)   RAM_FULL <= 1'b1;
            case (ctrl_state)
                IDLE: ;
                CAPTURE: begin
                    if (STOP || last_done) ctrl_state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty && (w_state == W_IDLE)) begin
                        ctrl_state <= IDLE;
                        BUSY       <= 1'b0;
                    end
                end
                default: begin
                    ctrl_state <= IDLE;
                    BUSY       <= 1'b0;
                end
            endcase
        end
    end

    // Write FSM: address and data only move while SRAM_WE_N is high.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            w_state    <= W_IDLE;
            SRAM_WE_N  <= 1'b1;
            SRAM_ADDR  <= '0;
            SRAM_DQ    <= '0;
            WORD_COUNT <= '0;
            abort_q    <= 1'b0;
        end else begin
            SRAM_WE_N <= 1'b1;
            if (START) WORD_COUNT <= '0;
            case (w_state)
                W_IDLE: begin
                    if (START) begin
                        SRAM_ADDR <= '0;
                    end else if (fifo_pop) begin
                        SRAM_DQ <= fifo_dout;
                        w_state <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    if (START) begin
                        SRAM_ADDR <= '0;
                        w_state   <= W_IDLE;
                    end else begin
                        SRAM_WE_N <= 1'b0;
                        w_state   <= W_STROBE;
                    end
                end
                W_STROBE: begin
                    // The strobe already running is let finish; its hold cycle is then discarded.
                    w_state <= W_HOLD;
                    if (START) abort_q <= 1'b1;
                end
                W_HOLD: begin
                    if (START || abort_q) begin
                        SRAM_ADDR <= '0;
                        abort_q   <= 1'b0;
                        w_state   <= W_IDLE;
                    end else begin
                        WORD_COUNT <= WORD_COUNT + 1'b1;
                        if (!at_last) SRAM_ADDR <= SRAM_ADDR + 1'b1;
                        if (fifo_pop) begin
                            SRAM_DQ <= fifo_dout;
                            w_state <= W_SETUP;
                        end else begin
                            w_state <= W_IDLE;
                        end
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule
